// File: rtl/evr_pkg.sv
// Shared constants and small decode helpers for the EVR event decoder slice.
package evr_pkg;

    localparam logic [7:0] EVCODE_SHIFT0    = 8'h70;
    localparam logic [7:0] EVCODE_SHIFT1    = 8'h71;
    localparam logic [7:0] EVCODE_HEARTBEAT = 8'h7A;
    localparam logic [7:0] EVCODE_SECONDS   = 8'h7D;
    localparam logic [7:0] K28_5            = 8'hBC;

    localparam int unsigned SECONDS_BITS = 32;

    function automatic logic is_event(input logic synced, input logic is_k, input logic [7:0] code);
        return synced && !is_k && (code != 8'h00);
    endfunction

    function automatic logic is_shift(input logic [7:0] code);
        return (code == EVCODE_SHIFT0) || (code == EVCODE_SHIFT1);
    endfunction

endpackage

// File: rtl/evr_event_decoder_if.sv
// Character stream from the transceiver wrapper into the event decoder.
interface evr_event_decoder_if;

    logic [15:0] evrChars;
    logic [1:0]  evrCharIsK;
    logic        evrRxSynchronized;

    modport master (output evrChars, output evrCharIsK, output evrRxSynchronized);
    modport slave  (input  evrChars, input  evrCharIsK, input  evrRxSynchronized);

endinterface

// File: rtl/evr_timestamp.sv
// Seconds shift register, bit counter and seconds/ticks/valid/error tracking.
module evr_timestamp
    import evr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    input  logic [7:0]  code,
    input  logic        valid,
    output logic [31:0] seconds,
    output logic [31:0] ticks,
    output logic        timestamp_valid,
    output logic        seconds_error
);

    localparam logic [5:0] BITS_FULL = 6'(SECONDS_BITS);

    logic [31:0] shift_reg;
    logic [5:0]  bit_count;

    // Later assignments take priority: a marker overrides the saturation clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg       <= '0;
            bit_count       <= '0;
            seconds         <= '0;
            ticks           <= '0;
            timestamp_valid <= 1'b0;
            seconds_error   <= 1'b0;
        end else begin
            if (ticks != '1) begin
                ticks <= ticks + 32'd1;
            end else begin
                timestamp_valid <= 1'b0;
            end

            if (!sync) begin
                timestamp_valid <= 1'b0;
                shift_reg       <= '0;
                bit_count       <= '0;
            end else if (valid && (code == EVCODE_SECONDS)) begin
                ticks     <= '0;
                shift_reg <= '0;
                bit_count <= '0;
                if (bit_count == BITS_FULL) begin
                    seconds         <= shift_reg;
                    timestamp_valid <= 1'b1;
                end else begin
                    seconds_error   <= 1'b1;
                    timestamp_valid <= 1'b0;
                end
            end else if (valid && is_shift(code)) begin
                shift_reg <= {shift_reg[30:0], code[0]};
                if (bit_count != BITS_FULL) begin
                    bit_count <= bit_count + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/evr_event_decoder.sv
// EVR event decoder: event qualification, distributed bus, heartbeat watchdog,
// trigger comparators, with the timestamp logic in evr_timestamp.
module evr_event_decoder
    import evr_pkg::*;
#(
    parameter int unsigned TRIGGER_COUNT     = 4,
    parameter int unsigned HEARTBEAT_TIMEOUT = 200000000
) (
    input  logic                         evrClk,
    input  logic                         evrReset,
    evr_event_decoder_if.slave           rx,
    input  logic [8*TRIGGER_COUNT-1:0]   triggerCodes,
    output logic [7:0]                   eventCode,
    output logic                         eventStrobe,
    output logic [7:0]                   distributedBus,
    output logic [31:0]                  seconds,
    output logic [31:0]                  ticks,
    output logic                         timestampValid,
    output logic                         secondsError,
    output logic                         heartbeatLost,
    output logic [TRIGGER_COUNT-1:0]     triggers
);

    localparam int unsigned WD_WIDTH = (HEARTBEAT_TIMEOUT > 1) ? $clog2(HEARTBEAT_TIMEOUT) : 1;
    localparam logic [WD_WIDTH-1:0] WD_RELOAD = WD_WIDTH'(HEARTBEAT_TIMEOUT - 1);

    logic [7:0]          code;
    logic                sync;
    logic                valid;
    logic                unused_k1;
    logic [WD_WIDTH-1:0] watchdog;

    assign code      = rx.evrChars[7:0];
    assign sync      = rx.evrRxSynchronized;
    assign valid     = is_event(sync, rx.evrCharIsK[0], code);
    assign unused_k1 = rx.evrCharIsK[1];

    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            eventCode      <= '0;
            eventStrobe    <= 1'b0;
            distributedBus <= '0;
            watchdog       <= WD_RELOAD;
            heartbeatLost  <= 1'b0;
            triggers       <= '0;
        end else begin
            eventStrobe <= valid;
            if (valid) begin
                eventCode <= code;
            end
            if (sync) begin
                distributedBus <= rx.evrChars[15:8];
            end

            if (valid && (code == EVCODE_HEARTBEAT)) begin
                watchdog      <= WD_RELOAD;
                heartbeatLost <= 1'b0;
            end else if (watchdog == '0) begin
                heartbeatLost <= 1'b1;
            end else begin
                watchdog <= watchdog - 1'b1;
            end

            for (int unsigned i = 0; i < TRIGGER_COUNT; i++) begin
                triggers[i] <= valid && (code == triggerCodes[8*i +: 8])
                               && (triggerCodes[8*i +: 8] != 8'h00);
            end
        end
    end

    evr_timestamp u_timestamp (
        .clk             (evrClk),
        .rst             (evrReset),
        .sync            (sync),
        .code            (code),
        .valid           (valid),
        .seconds         (seconds),
        .ticks           (ticks),
        .timestamp_valid (timestampValid),
        .seconds_error   (secondsError)
    );

endmodule
